// File: rtl/spare_scan_ctrl.sv
// Load / optional capture / unload sequencer for the spare-cell scan bank.
// All bank-facing and status outputs are registered from next-state values.
module spare_scan_ctrl #(
  parameter int CHAIN_LEN = 10
) (
  input  logic                 Clk,
  input  logic                 nReset,
  input  logic                 start,
  input  logic                 capture_en,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic [CHAIN_LEN-1:0] tmode_cfg,
  // "expect" is a reserved word in SystemVerilog, hence exp_word.
  input  logic [CHAIN_LEN-1:0] exp_word,
  input  logic [CHAIN_LEN-1:0] mask,
  input  logic                 so,
  output logic                 scen,
  output logic [CHAIN_LEN-1:0] tst_mode,
  output logic                 si,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [CHAIN_LEN-1:0] result,
  output logic [2:0]           dbg_state
);

  localparam int CW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CAPTURE = 3'd2,
    UNLOAD  = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] load_sh_q, load_sh_d;
  logic [CHAIN_LEN-1:0] tmode_q, tmode_d;
  logic [CHAIN_LEN-1:0] exp_q, exp_d;
  logic [CHAIN_LEN-1:0] mask_q, mask_d;
  logic                 cap_q, cap_d;
  logic [CHAIN_LEN-1:0] result_q, result_d;
  logic                 fail_q, fail_d;
  logic                 scen_q, scen_d;
  logic [CHAIN_LEN-1:0] tst_mode_q, tst_mode_d;
  logic                 si_q, si_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // start is a request qualified by !busy: it is taken on the edge ending an
  // IDLE cycle and ignored (not queued) at any other time.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_sh_d = load_sh_q;
    tmode_d   = tmode_q;
    exp_d     = exp_q;
    mask_d    = mask_q;
    cap_d     = cap_q;
    result_d  = result_q;
    fail_d    = fail_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          cnt_d     = '0;
          load_sh_d = pattern;
          tmode_d   = tmode_cfg;
          exp_d     = exp_word;
          mask_d    = mask;
          cap_d     = capture_en;
          result_d  = '0;
          fail_d    = 1'b0;
        end
      end
      LOAD: begin
        // MSB of the shifter is always the bit currently on si.
        load_sh_d = load_sh_q << 1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = cap_q ? CAPTURE : UNLOAD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CAPTURE: begin
        state_d = UNLOAD;
      end
      UNLOAD: begin
        // First bit out is flop CHAIN_LEN-1, so it ends up as the result MSB.
        result_d = {result_q[CHAIN_LEN-2:0], so};
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
          fail_d  = |((result_d ^ exp_q) & mask_q);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    scen_d     = (state_d == LOAD) || (state_d == UNLOAD);
    tst_mode_d = (state_d == CAPTURE) ? tmode_d : '0;
    si_d       = (state_d == LOAD) ? load_sh_d[CHAIN_LEN-1] : 1'b0;
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      load_sh_q  <= '0;
      tmode_q    <= '0;
      exp_q      <= '0;
      mask_q     <= '0;
      cap_q      <= 1'b0;
      result_q   <= '0;
      fail_q     <= 1'b0;
      scen_q     <= 1'b0;
      tst_mode_q <= '0;
      si_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      load_sh_q  <= load_sh_d;
      tmode_q    <= tmode_d;
      exp_q      <= exp_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      result_q   <= result_d;
      fail_q     <= fail_d;
      scen_q     <= scen_d;
      tst_mode_q <= tst_mode_d;
      si_q       <= si_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign scen      = scen_q;
  assign tst_mode  = tst_mode_q;
  assign si        = si_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: doc/spare_scan_ctrl.md
# spare_scan_ctrl

Sequencer for the spare-cell scan bank. It loads a pattern into the bank's 10-flop scan chain through `si`, optionally fires one functional capture cycle under per-bit `tst_mode` control, and unloads the chain through `so`. It then compares the unloaded word against an expected value and reports pass/fail. It sits beside the spare bank in the test wrapper and is the only driver of the bank's `scen`, `tst_mode` and `si`.

## Interface
- `CHAIN_LEN`, default 10: scan-chain length in flops; sets the width of all pattern-sized ports.
- `Clk` in 1: single clock, rising edge; same clock as the spare bank.
- `nReset` in 1: asynchronous, active-low reset; same net as the bank's `nReset`.
- `start` in 1: request one load/capture/unload sequence; sampled only in IDLE.
- `capture_en` in 1: when 1, insert the CAPTURE cycle; latched at start.
- `pattern` in CHAIN_LEN: word to load; bit i is the final value of chain flop i. Latched at start.
- `tmode_cfg` in CHAIN_LEN: `tst_mode` value driven during CAPTURE; latched at start.
- `expect` in CHAIN_LEN: expected unload word; latched at start.
- `mask` in CHAIN_LEN: 1 = compare bit, 0 = ignore; latched at start.
- `so` in 1: chain output (flop CHAIN_LEN-1 Q).
- `scen` out 1: scan enable to the bank.
- `tst_mode` out CHAIN_LEN: per-flop capture select to the bank.
- `si` out 1: chain input to flop 0.
- `busy` out 1: high from the accepted start until the DONE cycle ends.
- `done` out 1: one-cycle pulse marking valid result and fail.
- `fail` out 1: set when `(result ^ expect_q) & mask_q` is nonzero; held until the next accepted start.
- `result` out CHAIN_LEN: unloaded word; held until the next accepted start.

## Operation
- Bank flop behaviour that this block relies on:
  - `scen`=1: Q ← SCIN.
  - `scen`=0, `tst_mode[i]`=1: Q ← datain[i].
  - Otherwise the flop holds.
- FSM states: IDLE → LOAD → [CAPTURE] → UNLOAD → DONE → IDLE. All outputs are registered.
- IDLE:
  - `scen`=0, `tst_mode`=0, `si`=0, `busy`=0.
  - When `start`=1, latch `pattern`, `tmode_cfg`, `expect`, `mask` and `capture_en`, clear `fail` and `result`, go to LOAD.
- LOAD: CHAIN_LEN cycles, indexed by bit counter k = 0..CHAIN_LEN-1.
  - `scen`=1, `tst_mode`=0, `si`=pattern_q[CHAIN_LEN-1-k], so MSB first.
  - After the last cycle, go to CAPTURE if capture_en_q, else to UNLOAD.
- CAPTURE: exactly one cycle with `scen`=0 and `tst_mode`=tmode_cfg_q; then go to UNLOAD.
- UNLOAD: CHAIN_LEN cycles, k = 0..CHAIN_LEN-1.
  - `scen`=1, `si`=0.
  - At the rising edge ending cycle k, sample `so` into result[CHAIN_LEN-1-k].
- DONE: one cycle.
  - `done`=1, `busy`=1, `scen`=0, `tst_mode`=0.
  - `fail` updates at the edge entering DONE.
  - Go to IDLE.
- Counter: $clog2(CHAIN_LEN) bits; it wraps to 0 on every LOAD→next or UNLOAD→next transition.
- Boundary behaviour:
  - `start` while busy: ignored, no queuing.
  - `start` held high in IDLE after DONE: starts a new sequence the next cycle.
  - Input changes after start: no effect, because all inputs are latched.
  - capture_en=0: the result equals the loaded pattern; this is the chain-integrity check.
  - `mask`=0: `fail`=0 regardless of data.

## Timing
- Reset (async assert, sync-free deassert as seen by the FSM): state=IDLE, `scen`=0, `tst_mode`=0, `si`=0, `busy`=0, `done`=0, `fail`=0, `result`=0, counter=0.
- Reset mid-sequence: immediate return to the reset values. The bank resets on the same net, so no partial pattern survives.
- Let edge E0 be the edge where `start` is accepted. `busy` rises after E0. LOAD occupies cycles 1..CHAIN_LEN.
- With capture: CAPTURE is cycle CHAIN_LEN+1, UNLOAD is cycles CHAIN_LEN+2..2·CHAIN_LEN+1, DONE is cycle 2·CHAIN_LEN+2. For CHAIN_LEN=10, `done` is high during cycle 22.
- Without capture: each state after LOAD shifts one cycle earlier. DONE is cycle 2·CHAIN_LEN+1, which is cycle 21.
- `busy` falls after the DONE cycle. The earliest next start is accepted at the edge ending the DONE+1 cycle (IDLE).

## Test plan
- Chain integrity: capture_en=0, pattern=0x2A5, expect=0x2A5, mask=0x3FF → `done` in cycle 21, result=0x2A5, fail=0; `si` sequence is 1,0,1,0,1,0,0,1,0,1.
- Capture: capture_en=1, pattern=0x155, tmode_cfg=0x00F, bank datain=0x3F0 → result=0x150, `done` in cycle 22; `scen`=0 and `tst_mode`=0x00F in cycle 11 only.
- Mismatch and mask: capture_en=0, pattern=0x0F0, expect=0x0F1 with mask=0x3FF → fail=1. Same run with mask=0x3FE → fail=0.
- Busy protection: pulse `start` with pattern=0x3FF at E0, then `start` with pattern=0x000 in cycle 5 → exactly one `done` pulse, result=0x3FF.
- Reset mid-UNLOAD: drop `nReset` in cycle 15 → all outputs are at reset values within the same cycle. After release, a new run with pattern=0x1C3 and capture_en=0 gives result=0x1C3.
- Back-to-back: `start` held high for two runs → the second LOAD begins in the cycle after IDLE. Both `done` pulses are correct and `fail` is cleared at the second start.
